// File: rtl/tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// tx_sched_pkg
// Shared definitions for the egress strict-priority scheduler:
//   - sched_state_e : scheduler FSM state encoding
//   - DEF_*         : default parameter values used by tx_pri_sched
//   - clog2()       : index width for a given number of priority queues
// ---------------------------------------------------------------------------
package tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XMIT  = 2'd2,
    ST_IFG   = 2'd3
  } sched_state_e;

  localparam int DEF_PRI_NUM        = 8;
  localparam int DEF_IFG_CYCLES     = 12;
  localparam int DEF_TIMEOUT_CYCLES = 65535;
  localparam int DEF_TMO_CNT_WIDTH  = 16;

  // Width needed to hold an index in 0..value-1 (never less than 1 bit).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((32'sd1 <<< w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pri_encoder_hi.sv
// ---------------------------------------------------------------------------
// pri_encoder_hi
// Combinational highest-set-bit encoder.
// Ports:
//   req   [N-1:0]     : request vector
//   idx   [IDX_W-1:0] : index of the highest set bit of req (0 when none)
//   found             : at least one bit of req is set
// ---------------------------------------------------------------------------
module pri_encoder_hi #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Ascending scan: the last set bit visited is the highest one.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx   = req[i] ? IDX_W'(i) : idx;
      found = found | req[i];
    end
  end

endmodule

// File: rtl/tx_pri_sched.sv
// ---------------------------------------------------------------------------
// tx_pri_sched
// Egress strict-priority scheduler for one switch port. Samples the per-queue
// empty flags on each info strobe, grants the highest-priority non-empty,
// gate-open queue with a one-cycle one-hot read pulse, then follows the frame
// on the MAC AXI-stream to its last beat, inserts an inter-frame gap and
// aborts a frame that never finishes.
// Ports:
//   i_clk, i_rst                : clock, asynchronous active-high reset
//   i_tx_mac_forward_info[_vld] : per-queue empty flags (1 = empty) + strobe
//   o_fifo_pri_rd_en            : one-hot, one-cycle start pulse for a queue
//   i_mac_port_link, i_sched_en : link status / global enable (gate new grants)
//   i_queue_gate_en             : per-queue gate mask (1 = open)
//   i_mac_axi_data_*            : monitored egress stream handshake
//   o_sched_busy                : high in GRANT, XMIT and IFG
//   o_cur_pri                   : most recently granted queue index
//   o_timeout                   : one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module tx_pri_sched
  import tx_sched_pkg::*;
#(
  parameter int PORT_FIFO_PRI_NUM = DEF_PRI_NUM,
  parameter int IFG_CYCLES        = DEF_IFG_CYCLES,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
  parameter int TMO_CNT_WIDTH     = DEF_TMO_CNT_WIDTH,
  parameter int PRI_W             = clog2(PORT_FIFO_PRI_NUM)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [PORT_FIFO_PRI_NUM-1:0] i_tx_mac_forward_info,
  input  logic                         i_tx_mac_forward_info_vld,
  output logic [PORT_FIFO_PRI_NUM-1:0] o_fifo_pri_rd_en,
  input  logic                         i_mac_port_link,
  input  logic                         i_sched_en,
  input  logic [PORT_FIFO_PRI_NUM-1:0] i_queue_gate_en,
  input  logic                         i_mac_axi_data_valid,
  input  logic                         i_mac_axi_data_ready,
  input  logic                         i_mac_axi_data_last,
  output logic                         o_sched_busy,
  output logic [PRI_W-1:0]             o_cur_pri,
  output logic                         o_timeout
);

  localparam int IFG_CNT_W = clog2(IFG_CYCLES + 1);

  // Terminal counts; IFG_LAST is only consulted when IFG_CYCLES > 0.
  localparam logic [IFG_CNT_W-1:0]         IFG_LAST = IFG_CNT_W'(IFG_CYCLES - 1);
  localparam logic [TMO_CNT_WIDTH-1:0]     TMO_LAST = TMO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [PORT_FIFO_PRI_NUM-1:0] ONE_HOT0 = PORT_FIFO_PRI_NUM'(1'b1);

  sched_state_e                 state_r;
  logic [PORT_FIFO_PRI_NUM-1:0] snap_r;
  logic                         snap_vld_r;
  logic [PRI_W-1:0]             sel_r;
  logic [TMO_CNT_WIDTH-1:0]     wdog_r;
  logic [IFG_CNT_W-1:0]         ifg_cnt_r;
  logic [PORT_FIFO_PRI_NUM-1:0] rd_en_r;
  logic                         busy_r;
  logic [PRI_W-1:0]             cur_pri_r;
  logic                         timeout_r;

  logic [PORT_FIFO_PRI_NUM-1:0] elig_s;
  logic [PRI_W-1:0]             hi_idx_s;
  logic                         hi_found_s;
  logic                         last_hs_s;

  assign o_fifo_pri_rd_en = rd_en_r;
  assign o_sched_busy     = busy_r;
  assign o_cur_pri        = cur_pri_r;
  assign o_timeout        = timeout_r;

  assign last_hs_s = i_mac_axi_data_valid & i_mac_axi_data_ready & i_mac_axi_data_last;

  // Eligible queues: non-empty in a fresh snapshot, gate open, port usable.
  always_comb begin
    elig_s = '0;
    if (snap_vld_r && i_sched_en && i_mac_port_link) begin
      elig_s = ~snap_r & i_queue_gate_en;
    end else begin
      elig_s = '0;
    end
  end

  pri_encoder_hi #(
    .N     (PORT_FIFO_PRI_NUM),
    .IDX_W (PRI_W)
  ) u_pri_enc (
    .req   (elig_s),
    .idx   (hi_idx_s),
    .found (hi_found_s)
  );

  // Empty-flag snapshot. A grant consumes it so the same flags can never
  // start a second frame; a strobe landing on the grant cycle re-arms it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      snap_r     <= '1;
      snap_vld_r <= 1'b0;
    end else if (i_tx_mac_forward_info_vld) begin
      snap_r     <= i_tx_mac_forward_info;
      snap_vld_r <= 1'b1;
    end else if (state_r == ST_GRANT) begin
      snap_vld_r <= 1'b0;
    end
  end

  // Scheduler FSM with registered outputs, watchdog and inter-frame gap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      sel_r     <= '0;
      wdog_r    <= '0;
      ifg_cnt_r <= '0;
      rd_en_r   <= '0;
      busy_r    <= 1'b0;
      cur_pri_r <= '0;
      timeout_r <= 1'b0;
    end else begin
      rd_en_r   <= '0;
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (hi_found_s) begin
            sel_r   <= hi_idx_s;
            state_r <= ST_GRANT;
            busy_r  <= 1'b1;
          end
        end
        ST_GRANT: begin
          rd_en_r   <= ONE_HOT0 << sel_r;
          cur_pri_r <= sel_r;
          wdog_r    <= '0;
          state_r   <= ST_XMIT;
          busy_r    <= 1'b1;
        end
        ST_XMIT: begin
          // A last handshake wins over a watchdog expiring in the same cycle.
          if (last_hs_s) begin
            ifg_cnt_r <= '0;
            if (IFG_CYCLES == 0) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_IFG;
            end
          end else if (wdog_r == TMO_LAST) begin
            timeout_r <= 1'b1;
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
          end else begin
            wdog_r <= wdog_r + TMO_CNT_WIDTH'(1);
          end
        end
        ST_IFG: begin
          if (ifg_cnt_r == IFG_LAST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            ifg_cnt_r <= ifg_cnt_r + IFG_CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
